// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of one single-ported memory
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr/flush      fetch request (read-only), PC redirect
//   if_rdata/if_valid/if_stall fetch response and pipeline stall
//   dm_req/dm_we/dm_addr/dm_wdata  data request (load/store)
//   dm_rdata/dm_valid/dm_stall     data response and pipeline stall
//   mem_en/mem_we/mem_addr/mem_wdata  memory command, held until mem_ready
//   mem_rdata/mem_ready       memory response
module mem_port_arbiter #(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 16,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

    localparam int SW = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    state_t            state, state_d;
    logic [SW-1:0]     streak, streak_d;
    logic              discard, discard_d;
    logic              mem_en_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;
    logic              if_valid_d, dm_valid_d;

    // A requester whose valid is high this cycle still shows its old req,
    // so it must not be re-granted.
    logic if_live, dm_live, if_elig, grant_if, grant_dm;
    assign if_live  = if_req & ~if_valid;
    assign dm_live  = dm_req & ~dm_valid;
    assign if_elig  = if_live & ~flush;
    assign grant_if = (state == IDLE) & if_elig & (~dm_live | (streak == STREAK_MAX));
    assign grant_dm = (state == IDLE) & dm_live & ~grant_if;

    assign if_stall = if_req & ~if_valid;
    assign dm_stall = dm_req & ~dm_valid;

    always_comb begin
        state_d     = state;
        streak_d    = streak;
        discard_d   = discard;
        mem_en_d    = mem_en;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        if_rdata_d  = if_rdata;
        dm_rdata_d  = dm_rdata;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_if) begin
                    state_d    = IF_BUSY;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    streak_d   = '0;
                end else if (grant_dm) begin
                    state_d     = DM_BUSY;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    // Only count data grants that actually kept a fetch waiting.
                    if (if_live)
                        streak_d = (streak == STREAK_MAX) ? streak : streak + SW'(1);
                    else
                        streak_d = '0;
                end
            end
            IF_BUSY: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_en_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    discard_d = 1'b0;
                    // A redirect during or at completion turns the fetch stale.
                    if (!discard && !flush) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end
            DM_BUSY: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    mem_en_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    dm_valid_d = 1'b1;
                    if (!mem_we)
                        dm_rdata_d = mem_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            streak    <= '0;
            discard   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_valid  <= 1'b0;
        end else begin
            state     <= state_d;
            streak    <= streak_d;
            discard   <= discard_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            if_rdata  <= if_rdata_d;
            dm_rdata  <= dm_rdata_d;
            if_valid  <= if_valid_d;
            dm_valid  <= dm_valid_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int MAX_STREAK = 4;

    logic        clk = 1'b0;
    logic        rst, if_req, flush, dm_req, dm_we;
    logic [15:0] if_addr, dm_addr, dm_wdata;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_valid, if_stall, dm_valid, dm_stall, mem_en, mem_we, mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.DATA_W(16), .ADDR_W(16), .MAX_DM_STREAK(MAX_STREAK)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .flush(flush),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Reference: who owns the memory, what command is expected on it, and
    // the memory itself (256 words, indexed by the low address byte).
    int          m_owner, m_streak, m_cnt, m_lat, m_grant;
    logic        m_en, m_we, m_if_valid, m_dm_valid, m_discard;
    logic [15:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;
    logic [15:0] mem_arr [0:255];
    int          next_lat = 1;
    logic        idle_noise = 1'b0;
    logic [15:0] noise_rdata = 16'h0;
    logic        resp_ready;
    logic [15:0] last_load, last_fetch;

    assign resp_ready = m_en && (m_cnt >= m_lat);
    assign mem_ready  = m_en ? resp_ready : idle_noise;
    assign mem_rdata  = resp_ready ? mem_arr[m_addr[7:0]] : noise_rdata;

    function automatic int pick(logic f_live, logic d_live, logic fl, int streak);
        logic f_ok;
        f_ok = f_live && !fl;
        if (d_live && !(f_ok && streak >= MAX_STREAK)) return 2;
        if (f_ok) return 1;
        return 0;
    endfunction

    always_comb begin
        m_grant = 0;
        if (m_owner == 0)
            m_grant = pick(if_req && !m_if_valid, dm_req && !m_dm_valid, flush, m_streak);
    end

    always @(posedge clk) begin
        if (rst) begin
            m_owner <= 0; m_streak <= 0; m_cnt <= 0; m_lat <= 1;
            m_en <= 0; m_we <= 0; m_addr <= 0; m_wdata <= 0; m_discard <= 0;
            m_if_valid <= 0; m_dm_valid <= 0; m_if_rdata <= 0; m_dm_rdata <= 0;
            for (int i = 0; i < 256; i++) mem_arr[i] <= 16'(i * 40503 + 12345);
        end else begin
            m_if_valid <= 0;
            m_dm_valid <= 0;
            if (m_owner == 0) begin
                if (m_grant == 1) begin
                    m_owner <= 1; m_en <= 1; m_we <= 0; m_addr <= if_addr;
                    m_cnt <= 1; m_lat <= next_lat; m_streak <= 0;
                end else if (m_grant == 2) begin
                    m_owner <= 2; m_en <= 1; m_we <= dm_we; m_addr <= dm_addr; m_wdata <= dm_wdata;
                    m_cnt <= 1; m_lat <= next_lat;
                    if (if_req && !m_if_valid)
                        m_streak <= (m_streak + 1 > MAX_STREAK) ? MAX_STREAK : m_streak + 1;
                    else
                        m_streak <= 0;
                end
            end else if (resp_ready) begin
                m_owner <= 0; m_en <= 0; m_we <= 0;
                if (m_owner == 1) begin
                    m_discard <= 0;
                    if (!m_discard && !flush) begin
                        m_if_valid <= 1; m_if_rdata <= mem_rdata;
                    end
                end else begin
                    m_dm_valid <= 1;
                    if (m_we) mem_arr[m_addr[7:0]] <= m_wdata;
                    else      m_dm_rdata <= mem_rdata;
                end
            end else begin
                m_cnt <= m_cnt + 1;
                if (m_owner == 1 && flush) m_discard <= 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; if_req = 1; if_addr = 16'h1234; flush = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        step(); step();
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en got %h want 0", mem_en); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we got %h want 0", mem_we); end
        n_checks++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
        n_checks++; if (mem_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
        n_checks++; if (if_rdata !== 16'h0) begin n_fail++; $display("FAIL rst_if_rdata got %h want 0", if_rdata); end
        n_checks++; if (dm_rdata !== 16'h0) begin n_fail++; $display("FAIL rst_dm_rdata got %h want 0", dm_rdata); end
        n_checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valids got %b%b want 00", if_valid, dm_valid); end
        n_checks++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL rst_if_stall got %h want 1", if_stall); end
        n_checks++; if (dm_stall !== 1'b0) begin n_fail++; $display("FAIL rst_dm_stall got %h want 0", dm_stall); end
        if_req = 0; rst = 0;
        step();
    endtask

    task automatic test_single_fetch();
        logic [15:0] exp;
        step(); next_lat = 1; if_req = 1; if_addr = 16'h0010; exp = mem_arr[8'h10];
        @(negedge clk);
        n_checks++; if (if_stall !== 1'b1 || mem_en !== 1'b0) begin n_fail++; $display("FAIL sf_c0 stall/en got %b%b want 10", if_stall, mem_en); end
        step(); @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0010) begin n_fail++; $display("FAIL sf_c1 en/addr got %b/%h want 1/0010", mem_en, mem_addr); end
        n_checks++; if (if_stall !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL sf_c1 stall/we got %b%b want 10", if_stall, mem_we); end
        step(); @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_rdata !== exp) begin n_fail++; $display("FAIL sf_c2 valid/rdata got %b/%h want 1/%h", if_valid, if_rdata, exp); end
        n_checks++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL sf_c2 stall got %b want 0", if_stall); end
        if_req = 0;
        step(); @(negedge clk);
        n_checks++; if (if_valid !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL sf_c3 valid/en got %b%b want 00", if_valid, mem_en); end
    endtask

    task automatic test_simultaneous();
        logic [15:0] ei, ed;
        step(); next_lat = 1;
        if_req = 1; if_addr = 16'h0020; dm_req = 1; dm_we = 0; dm_addr = 16'h0200;
        ei = mem_arr[8'h20]; ed = mem_arr[8'h00];
        @(negedge clk);
        step(); @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0200 || mem_we !== 1'b0) begin n_fail++; $display("FAIL sim_c1 en/addr/we got %b/%h/%b want 1/0200/0", mem_en, mem_addr, mem_we); end
        step(); @(negedge clk);
        n_checks++; if (dm_valid !== 1'b1 || dm_rdata !== ed) begin n_fail++; $display("FAIL sim_c2 dm valid/rdata got %b/%h want 1/%h", dm_valid, dm_rdata, ed); end
        n_checks++; if (mem_en !== 1'b0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL sim_c2 en/if_valid got %b%b want 00", mem_en, if_valid); end
        dm_req = 0;
        step(); @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0020) begin n_fail++; $display("FAIL sim_c3 en/addr got %b/%h want 1/0020", mem_en, mem_addr); end
        step(); @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_rdata !== ei) begin n_fail++; $display("FAIL sim_c4 if valid/rdata got %b/%h want 1/%h", if_valid, if_rdata, ei); end
        if_req = 0;
        last_load = ed; last_fetch = ei;
        step();
    endtask

    task automatic test_store();
        step(); next_lat = 2; dm_req = 1; dm_we = 1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL st_c0 en got %b want 0", mem_en); end
        for (int c = 1; c <= 2; c++) begin
            step(); @(negedge clk);
            n_checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 16'hBEEF || mem_addr !== 16'h0100 || dm_valid !== 1'b0) begin
                n_fail++; $display("FAIL st_busy c%0d en/we/wdata/addr/valid got %b/%b/%h/%h/%b want 1/1/beef/0100/0", c, mem_en, mem_we, mem_wdata, mem_addr, dm_valid);
            end
        end
        step(); @(negedge clk);
        n_checks++; if (dm_valid !== 1'b1 || dm_rdata !== last_load || mem_en !== 1'b0) begin n_fail++; $display("FAIL st_c3 valid/rdata/en got %b/%h/%b want 1/%h/0", dm_valid, dm_rdata, mem_en, last_load); end
        dm_req = 0; dm_we = 0;
        step(); @(negedge clk);
        n_checks++; if (dm_valid !== 1'b0 || dm_rdata !== last_load) begin n_fail++; $display("FAIL st_c4 valid/rdata got %b/%h want 0/%h", dm_valid, dm_rdata, last_load); end
    endtask

    task automatic test_flush();
        logic [15:0] exp;
        step(); next_lat = 3; if_req = 1; if_addr = 16'h0030;
        @(negedge clk);
        step(); @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0030) begin n_fail++; $display("FAIL fl_c1 en/addr got %b/%h want 1/0030", mem_en, mem_addr); end
        step(); flush = 1; if_addr = 16'h0040; @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0030) begin n_fail++; $display("FAIL fl_c2 en/addr got %b/%h want 1/0030", mem_en, mem_addr); end
        step(); flush = 0; @(negedge clk);
        n_checks++; if (if_valid !== 1'b0 || mem_en !== 1'b1) begin n_fail++; $display("FAIL fl_c3 valid/en got %b%b want 01", if_valid, mem_en); end
        step(); next_lat = 1; exp = mem_arr[8'h40]; @(negedge clk);
        n_checks++; if (if_valid !== 1'b0 || if_rdata !== last_fetch) begin n_fail++; $display("FAIL fl_c4 valid/rdata got %b/%h want 0/%h", if_valid, if_rdata, last_fetch); end
        n_checks++; if (mem_en !== 1'b0 || if_stall !== 1'b1) begin n_fail++; $display("FAIL fl_c4 en/stall got %b%b want 01", mem_en, if_stall); end
        step(); @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0040) begin n_fail++; $display("FAIL fl_c5 en/addr got %b/%h want 1/0040", mem_en, mem_addr); end
        step(); @(negedge clk);
        n_checks++; if (if_valid !== 1'b1 || if_rdata !== exp) begin n_fail++; $display("FAIL fl_c6 valid/rdata got %b/%h want 1/%h", if_valid, if_rdata, exp); end
        if_req = 0;
        step();
    endtask

    // Holding flush keeps the fetch ungrantable but still waiting, so the
    // data port builds a streak; the guard then forces the fetch in.
    task automatic test_starvation();
        int pulses = 0;
        int early  = 0;
        step(); next_lat = 1;
        dm_req = 1; dm_we = 0; dm_addr = 16'h0300;
        if_req = 1; if_addr = 16'h0050; flush = 1;
        for (int cyc = 0; cyc < 60 && pulses < 4; cyc++) begin
            @(negedge clk);
            if (mem_en === 1'b1 && mem_addr === 16'h0050) early++;
            if (dm_valid === 1'b1) begin
                pulses++;
                dm_addr = 16'h0300 + 16'(pulses);
            end
        end
        n_checks++; if (pulses != 4) begin n_fail++; $display("FAIL sv_pulses got %0d want 4", pulses); end
        n_checks++; if (early != 0) begin n_fail++; $display("FAIL sv_early_fetch got %0d want 0", early); end
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL sv_idle en got %b want 0", mem_en); end
        flush = 0;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0050 || mem_we !== 1'b0) begin n_fail++; $display("FAIL sv_guard en/addr/we got %b/%h/%b want 1/0050/0", mem_en, mem_addr, mem_we); end
        @(negedge clk);
        n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL sv_if_valid got %b want 1", if_valid); end
        if_req = 0;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0304) begin n_fail++; $display("FAIL sv_dm_resume en/addr got %b/%h want 1/0304", mem_en, mem_addr); end
        @(negedge clk);
        n_checks++; if (dm_valid !== 1'b1) begin n_fail++; $display("FAIL sv_dm_valid got %b want 1", dm_valid); end
        dm_addr = 16'h0305;
        @(negedge clk);
        if_req = 1; if_addr = 16'h0060;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0305) begin n_fail++; $display("FAIL sv_streak_cleared en/addr got %b/%h want 1/0305", mem_en, mem_addr); end
        @(negedge clk);
        dm_req = 0;
        @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0060) begin n_fail++; $display("FAIL sv_if_after en/addr got %b/%h want 1/0060", mem_en, mem_addr); end
        @(negedge clk);
        if_req = 0;
        step();
    endtask

    task automatic test_reset_midop();
        logic [15:0] exp;
        step(); next_lat = 3; dm_req = 1; dm_we = 0; dm_addr = 16'h0400;
        @(negedge clk);
        step(); @(negedge clk);
        n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL rm_c1 en got %b want 1", mem_en); end
        step(); rst = 1; @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || dm_stall !== 1'b1 || dm_valid !== 1'b0) begin n_fail++; $display("FAIL rm_c2 en/stall/valid got %b%b%b want 110", mem_en, dm_stall, dm_valid); end
        step(); rst = 0; @(negedge clk);
        n_checks++; if (mem_en !== 1'b0 || dm_valid !== 1'b0) begin n_fail++; $display("FAIL rm_c3 en/valid got %b%b want 00", mem_en, dm_valid); end
        exp = mem_arr[8'h00];
        step(); @(negedge clk);
        n_checks++; if (mem_en !== 1'b1 || mem_addr !== 16'h0400) begin n_fail++; $display("FAIL rm_c4 en/addr got %b/%h want 1/0400", mem_en, mem_addr); end
        for (int c = 5; c <= 6; c++) begin
            step(); @(negedge clk);
            n_checks++; if (dm_valid !== 1'b0) begin n_fail++; $display("FAIL rm_c%0d valid got %b want 0", c, dm_valid); end
        end
        step(); @(negedge clk);
        n_checks++; if (dm_valid !== 1'b1 || dm_rdata !== exp) begin n_fail++; $display("FAIL rm_c7 valid/rdata got %b/%h want 1/%h", dm_valid, dm_rdata, exp); end
        dm_req = 0;
        step();
    endtask

    task automatic test_random(int cycles);
        step(); if_req = 0; dm_req = 0; flush = 0; rst = 1;
        step(); rst = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            rst         = ($urandom_range(0, 299) == 0);
            next_lat    = $urandom_range(1, 4);
            idle_noise  = ($urandom_range(0, 3) == 0);
            noise_rdata = 16'($urandom);
            if (!if_req || m_if_valid) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = 16'($urandom);
            end
            flush = ($urandom_range(0, 7) == 0);
            if (flush && if_req) if_addr = 16'($urandom);
            if (!dm_req || m_dm_valid) begin
                dm_req   = ($urandom_range(0, 1) != 0);
                dm_we    = ($urandom_range(0, 1) != 0);
                dm_addr  = 16'($urandom);
                dm_wdata = 16'($urandom);
            end
            @(negedge clk);
            n_checks++; if (mem_en !== m_en) begin n_fail++; $display("FAIL rnd_mem_en cyc %0d got %b want %b", i, mem_en, m_en); end
            if (m_en) begin
                n_checks++; if (mem_addr !== m_addr || mem_we !== m_we) begin n_fail++; $display("FAIL rnd_cmd cyc %0d addr/we got %h/%b want %h/%b", i, mem_addr, mem_we, m_addr, m_we); end
                if (m_we) begin
                    n_checks++; if (mem_wdata !== m_wdata) begin n_fail++; $display("FAIL rnd_wdata cyc %0d got %h want %h", i, mem_wdata, m_wdata); end
                end
            end
            n_checks++; if (if_valid !== m_if_valid) begin n_fail++; $display("FAIL rnd_if_valid cyc %0d got %b want %b", i, if_valid, m_if_valid); end
            n_checks++; if (dm_valid !== m_dm_valid) begin n_fail++; $display("FAIL rnd_dm_valid cyc %0d got %b want %b", i, dm_valid, m_dm_valid); end
            n_checks++; if (if_rdata !== m_if_rdata) begin n_fail++; $display("FAIL rnd_if_rdata cyc %0d got %h want %h", i, if_rdata, m_if_rdata); end
            n_checks++; if (dm_rdata !== m_dm_rdata) begin n_fail++; $display("FAIL rnd_dm_rdata cyc %0d got %h want %h", i, dm_rdata, m_dm_rdata); end
            n_checks++; if (if_stall !== (if_req && !m_if_valid)) begin n_fail++; $display("FAIL rnd_if_stall cyc %0d got %b want %b", i, if_stall, if_req && !m_if_valid); end
            n_checks++; if (dm_stall !== (dm_req && !m_dm_valid)) begin n_fail++; $display("FAIL rnd_dm_stall cyc %0d got %b want %b", i, dm_stall, dm_req && !m_dm_valid); end
        end
        step(); rst = 0; if_req = 0; dm_req = 0; flush = 0; idle_noise = 0;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_store();
        test_flush();
        test_starvation();
        test_reset_midop();
        test_random(3000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port (IF stage, read-only) and the data port (MEM stage, load/store).
- Sequences each access through a req/ready memory handshake of variable latency.
- Returns read data and one-cycle valid pulses to each requester, and drives per-port stall signals into the pipeline.
- Data port has priority, with a bounded-starvation guard for fetch; branch/call/ret redirects flush in-flight fetches.

Parameters:
- DATA_W, 16, memory word width.
- ADDR_W, 16, word address width.
- MAX_DM_STREAK, 4, consecutive data grants allowed while a fetch waits (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address (PC), stable while if_req
- flush  in  1  PC redirect; cancels pending or in-flight fetch
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  one-cycle pulse: if_rdata valid
- if_stall  out  1  if_req & ~if_valid (combinational)
- dm_req  in  1  data request, held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data
- dm_valid  out  1  one-cycle pulse: access complete
- dm_stall  out  1  dm_req & ~dm_valid (combinational)
- mem_en  out  1  memory command valid
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  access complete this cycle

Behaviour:
- FSM states: IDLE, IF_BUSY, DM_BUSY.
- Reset values:
  - state IDLE; streak counter 0; discard flag 0.
  - mem_en, mem_we, if_valid, dm_valid = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - Stall outputs are combinational, so if_stall/dm_stall = 1 during reset whenever the matching req is high.
- Masking: a port whose valid is asserted in the current cycle is ignored by arbitration that cycle; its req is stale.
- IDLE grant rules (unmasked requests only):
  - Only dm_req: grant DM.
  - Only if_req and flush=0: grant IF.
  - Both: grant DM unless streak == MAX_DM_STREAK, then grant IF.
  - if_req with flush=1: not granted this cycle.
- On grant, capture the address (plus we/wdata for DM) into mem_* registers, set mem_en=1 at the next edge, and enter the matching BUSY state.
- BUSY:
  - mem_en/mem_we/mem_addr/mem_wdata stay stable until mem_ready is sampled high.
  - On mem_ready: next edge sets mem_en=0, returns to IDLE, and pulses the port valid for exactly one cycle.
  - Loads register mem_rdata into the port rdata; stores leave dm_rdata unchanged.
- Latency: request seen in IDLE at cycle 0, mem_en high from cycle 1, mem_ready at cycle k≥1 → valid at cycle k+1. A back-to-back grant to the other port can occur in cycle k+1, giving mem_en again at k+2.
- Streak counter:
  - Increments on each DM grant made while an unmasked if_req is high.
  - Clears on any IF grant, and on a DM grant made while if_req is low.
  - Saturates at MAX_DM_STREAK.
- Flush:
  - flush in IF_BUSY sets discard. The memory access completes normally, but if_valid is suppressed, if_rdata is not updated, and discard clears on return to IDLE.
  - flush in the completion cycle (mem_ready high) also suppresses.
  - flush during DM_BUSY or IDLE without fetch: no effect.
- rst mid-operation: next edge forces IDLE and clears mem_en and both valids. The in-flight access is abandoned; the memory must tolerate mem_en dropping before ready.
- mem_ready while IDLE: ignored.
- No timeout: the arbiter waits on mem_ready indefinitely.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0010 at c0; memory returns 0xA5A5 with mem_ready at c1 → mem_en=1/mem_addr=0x0010 at c1, if_valid=1 and if_rdata=0xA5A5 at c2, if_stall=1 at c0–c1, 0 at c2.
- Simultaneous requests: if_req (0x0020) and dm_req load (0x0200) at c0, ready latency 1 → DM on memory c1, dm_valid c2, IF granted c2, mem_addr=0x0020 at c3, if_valid c4.
- Starvation guard: MAX_DM_STREAK=4, dm_req held continuously with changing addresses, if_req held → exactly 4 dm_valid pulses, then IF served, then DM resumes; streak returns to 0.
- Flush in flight: fetch 0x0030 granted, mem_ready delayed 3 cycles, flush pulsed 1 cycle after mem_en rises → no if_valid and if_rdata unchanged. New if_addr=0x0040 is then granted in IDLE and returns normally.
- Store: dm_we=1, dm_addr=0x0100, dm_wdata=0xBEEF, ready latency 2 → mem_we=1/mem_wdata=0xBEEF held 2 cycles, one dm_valid pulse, dm_rdata keeps its prior value.
- Reset mid-op: rst asserted for 1 cycle during DM_BUSY before mem_ready → next cycle mem_en=0 and dm_valid never pulses for that access. After rst deasserts, the held dm_req is re-granted from IDLE.
